// File: rtl/coreir_unconcat_ser_if.sv
// Handshake bundle for coreir_unconcat_ser: one wide word in, chunk-wide slices out.
// slave is the splitter's view, master is the producer/consumer side.
interface coreir_unconcat_ser_if #(
    parameter int width = 16,
    parameter int chunk = 4
);
    localparam int NUM = width / chunk;
    localparam int IW  = (NUM > 1) ? $clog2(NUM) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [width-1:0] in;
    logic             out_valid;
    logic             out_ready;
    logic [chunk-1:0] out;
    logic [IW-1:0]    out_idx;
    logic             out_last;

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, out, out_idx, out_last
    );

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, out, out_idx, out_last
    );
endinterface

// File: rtl/coreir_unconcat_ser.sv
// Streaming splitter (inverse of concat): one width-bit word in, width/chunk slices out.
// Define COREIR_UNCONCAT_MSB_FIRST_EN to emit the most significant slice first.
module coreir_unconcat_ser #(
    parameter int width = 16,
    parameter int chunk = 4
) (
    input  logic                 clk,
    input  logic                 arst_n,
    coreir_unconcat_ser_if.slave bus
);
    localparam int NUM = width / chunk;
    localparam int IW  = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [IW-1:0] LAST     = IW'(NUM - 1);
    localparam logic [IW-1:0] PRE_LAST = IW'((NUM > 1) ? NUM - 2 : 0);

    generate
        if (chunk < 1 || chunk > width || (width % chunk) != 0) begin : g_bad_cfg
            $error("coreir_unconcat_ser: width must be a positive multiple of chunk");
        end
    endgenerate

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                    state;
    logic [NUM-1:0][chunk-1:0] word;
    logic [IW-1:0]             idx;
    logic                      out_valid_q;
    logic                      out_last_q;
    logic                      run;   // holds in_ready low until the first edge after reset
    logic [IW-1:0]             sel;

    // A new word may enter when idle, or on the final slice's handshake (no bubble).
    assign bus.in_ready = run && ((state == IDLE) ||
                                  (state == BUSY && out_last_q && bus.out_ready));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= IDLE;
            word        <= '0;
            idx         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            run         <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        word        <= bus.in;
                        idx         <= '0;
                        state       <= BUSY;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (NUM == 1);
                    end
                end
                BUSY: begin
                    if (bus.out_ready) begin
                        if (!out_last_q) begin
                            idx        <= idx + IW'(1);
                            out_last_q <= (idx == PRE_LAST);
                        end else if (bus.in_valid) begin
                            word       <= bus.in;
                            idx        <= '0;
                            out_last_q <= (NUM == 1);
                        end else begin
                            state       <= IDLE;
                            idx         <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COREIR_UNCONCAT_MSB_FIRST_EN
    assign sel = LAST - idx;
`else
    assign sel = idx;
`endif

    // Slice mux reads only the word register, so out never sees in combinationally.
    generate
        if (NUM == 1) begin : g_single
            assign bus.out = word[0];
        end else begin : g_multi
            assign bus.out = word[sel];
        end
    endgenerate

    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = idx;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_coreir_unconcat_ser.sv
// Self-checking bench for coreir_unconcat_ser: directed tables, corner sequences,
// and random traffic against a queue-of-slices reference model.
module tb_coreir_unconcat_ser;
`ifdef COREIR_UNCONCAT_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif
    localparam int NUM = 4;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    coreir_unconcat_ser_if #(.width(16), .chunk(4)) b   ();
    coreir_unconcat_ser_if #(.width(8),  .chunk(8)) b8  ();
    coreir_unconcat_ser_if #(.width(12), .chunk(3)) b12 ();

    coreir_unconcat_ser #(.width(16), .chunk(4)) dut   (.clk(clk), .arst_n(arst_n), .bus(b));
    coreir_unconcat_ser #(.width(8),  .chunk(8)) dut8  (.clk(clk), .arst_n(arst_n), .bus(b8));
    coreir_unconcat_ser #(.width(12), .chunk(3)) dut12 (.clk(clk), .arst_n(arst_n), .bus(b12));

    typedef struct {
        logic [3:0] d;
        int         i;
        logic       l;
    } slice_t;

    typedef struct {
        logic [15:0] w;
        logic [3:0]  e [4];   // expected slices, LSB-first order
    } vec_t;

    slice_t     q[$];
    logic [3:0] log_q[$];
    bit         m_run = 1'b0;
    bit         last_acc = 1'b0;
    int         ncyc = 0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: check against the model at negedge, advance the model at posedge.
    task automatic cycle();
        bit         exp_rdy, fire, acc;
        logic [15:0] w;
        @(negedge clk);
        exp_rdy = m_run && (q.size() == 0 || (q.size() == 1 && b.out_ready));
        chk("in_ready", b.in_ready, exp_rdy);
        if (q.size() > 0) begin
            chk("out_valid", b.out_valid, 1);
            chk("out", b.out, q[0].d);
            chk("out_idx", b.out_idx, q[0].i);
            chk("out_last", b.out_last, q[0].l);
        end else begin
            chk("out_valid_idle", b.out_valid, 0);
        end
        fire = b.out_ready && (q.size() > 0);
        acc  = b.in_valid && exp_rdy;
        w    = b.in;
        if (fire) log_q.push_back(b.out);
        @(posedge clk);
        #1;
        if (fire) void'(q.pop_front());
        if (acc) begin
            for (int k = 0; k < NUM; k++) begin
                slice_t s;
                int     pos;
                pos = MSB ? (NUM - 1 - k) : k;
                s.d = 4'((w >> (4 * pos)) & 16'hF);
                s.i = k;
                s.l = (k == NUM - 1);
                q.push_back(s);
            end
        end
        m_run    = 1'b1;
        last_acc = acc;
        ncyc++;
    endtask

    task automatic send(input logic [15:0] w);
        int n;
        b.in_valid = 1'b1;
        b.in       = w;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) chk("send_timeout", 0, 1);
        b.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        b.out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            cycle();
            n++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
        cycle();
    endtask

    task automatic chk_log(input string name, input logic [3:0] e [8], input int n);
        chk({name, "_len"}, log_q.size(), n);
        for (int k = 0; k < n && k < log_q.size(); k++) begin
            int g;
            g = MSB ? ((k / 4) * 4 + 3 - (k % 4)) : k;
            chk(name, log_q[k], e[g]);
        end
    endtask

    vec_t       tbl [4];
    logic [3:0] e8 [8];
    int         c0;

    initial begin
        tbl[0].w = 16'hA5C3; tbl[0].e = '{4'h3, 4'hC, 4'h5, 4'hA};
        tbl[1].w = 16'h0F0F; tbl[1].e = '{4'hF, 4'h0, 4'hF, 4'h0};
        tbl[2].w = 16'hFFFF; tbl[2].e = '{4'hF, 4'hF, 4'hF, 4'hF};
        tbl[3].w = 16'h9006; tbl[3].e = '{4'h6, 4'h0, 4'h0, 4'h9};

        b.in_valid = 0; b.in = '0; b.out_ready = 1;
        b8.in_valid = 0; b8.in = '0; b8.out_ready = 1;
        b12.in_valid = 0; b12.in = '0; b12.out_ready = 1;

        // Reset state
        #2;
        chk("rst_in_ready", b.in_ready, 0);
        chk("rst_out_valid", b.out_valid, 0);
        chk("rst_out", b.out, 0);
        chk("rst_out_idx", b.out_idx, 0);
        chk("rst_out_last", b.out_last, 0);
        @(posedge clk); @(negedge clk);
        chk("rst_in_ready_held", b.in_ready, 0);
        @(posedge clk); #1;
        arst_n = 1'b1;
        cycle();

        // Directed table of single words
        foreach (tbl[t]) begin
            logic [3:0] e [8];
            for (int k = 0; k < 8; k++) e[k] = tbl[t].e[k % 4];
            log_q.delete();
            send(tbl[t].w);
            drain();
            chk_log("table", e, 4);
        end

        // Back-to-back, second word must follow with no bubble
        log_q.delete();
        e8 = '{4'h4, 4'h3, 4'h2, 4'h1, 4'hF, 4'hE, 4'hE, 4'hB};
        send(16'h1234);
        c0 = ncyc;
        send(16'hBEEF);
        chk("b2b_gap", ncyc - c0, 4);
        drain();
        chk_log("b2b", e8, 8);

        // Backpressure at idx 1 for three cycles
        log_q.delete();
        send(16'h00F0);
        c0 = ncyc;
        cycle();
        b.out_ready = 1'b0;
        repeat (3) cycle();
        b.out_ready = 1'b1;
        while (q.size() > 0 && ncyc - c0 < 20) cycle();
        chk("bp_cycles", ncyc - c0, 7);
        e8 = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
        chk_log("bp", e8, 4);
        cycle();

        // Reset mid-word at idx 2
        send(16'h8421);
        cycle(); cycle();
        #2 arst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", b.out_valid, 0);
        chk("mid_rst_out", b.out, 0);
        chk("mid_rst_in_ready", b.in_ready, 0);
        q.delete(); m_run = 1'b0;
        @(posedge clk); #1;
        arst_n = 1'b1;
        log_q.delete();
        repeat (4) cycle();
        chk("mid_rst_leftover", log_q.size(), 0);
        send(16'h0001);
        drain();
        e8 = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
        chk_log("post_rst", e8, 4);

        // Random traffic against the model; producer holds in until accepted
        b.in_valid = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!b.in_valid || last_acc) begin
                b.in_valid = ($urandom_range(0, 3) != 0);
                b.in       = 16'($urandom);
            end
            b.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        b.in_valid = 1'b0;
        drain();

        // width=8, chunk=8: one-deep pipe, every slice is last
        b8.in_valid = 1'b1; b8.in = 8'h11;
        @(negedge clk);
        chk("w8_in_ready", b8.in_ready, 1);
        @(posedge clk); #1;
        b8.in = 8'h22;
        @(negedge clk);
        chk("w8_out0", b8.out, 8'h11);
        chk("w8_last0", b8.out_last, 1);
        chk("w8_ready0", b8.in_ready, 1);
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        @(negedge clk);
        chk("w8_out1", b8.out, 8'h22);
        chk("w8_last1", b8.out_last, 1);
        chk("w8_valid1", b8.out_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w8_idle", b8.out_valid, 0);

        // width=12, chunk=3
        @(posedge clk); #1;
        b12.in_valid = 1'b1; b12.in = 12'hFFF;
        @(posedge clk); #1;
        b12.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("w12_out", b12.out, 3'b111);
            chk("w12_idx", b12.out_idx, k);
            chk("w12_last", b12.out_last, (k == 3));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("w12_idle", b12.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule

// File: doc/coreir_unconcat_ser.md
Name: coreir_unconcat_ser

Overview:
- Streaming splitter and the inverse of coreir.concat.
- Accepts one width-bit word over a valid/ready handshake and emits it as width/chunk slices of chunk bits, one slice per out handshake.
- Slice k is bits [(k+1)*chunk-1 : k*chunk]. Default order is LSB-first, so in0 of a matching concat is emitted first.
- Sits between wide datapath nodes and narrow links; a downstream collector rebuilds the word by concatenation.

Parameters:
- width, 16, total input word width in bits; must be an integer multiple of chunk.
- chunk, 4, output slice width in bits; 1 <= chunk <= width.
- NUM (localparam), width/chunk, slices per word.
- IW (localparam), max(1, clog2(NUM)), width of the slice index.

Ports:
- clk  input  1  clock, rising edge.
- arst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word this cycle.
- in  input  width  input word.
- out_valid  output  1  out holds a valid slice.
- out_ready  input  1  consumer accepts the slice this cycle.
- out  output  chunk  current slice.
- out_idx  output  IW  index of the current slice within its word (0..NUM-1).
- out_last  output  1  current slice is the final slice of its word.

Behaviour:
- Asynchronous reset (arst_n low):
  - state=IDLE, word register=0, idx=0.
  - out_valid=0, out=0, out_idx=0, out_last=0.
  - in_ready=0 while reset is asserted; in_ready=1 from the first edge after release.
  - Reset mid-word discards the word. No slice of it appears after release.
- FSM, two states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, capture in into the word register, set idx=0, go to BUSY.
  - BUSY: out_valid=1, out = slice idx of the captured word, out_idx=idx, out_last=(idx==NUM-1).
  - BUSY, out_ready=1 and not last: idx increments.
  - BUSY, out_ready=1 and last: word is complete. If in_valid=1 in the same cycle, capture the new word, set idx=0 and stay in BUSY (back-to-back, no bubble). Otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==BUSY && out_last && out_ready).
  - in_ready is combinational from out_ready; it is the only combinational in-to-out path.
- Output registering: out, out_valid, out_idx and out_last come from registers or the word register. out has no combinational path from in.
- Latency:
  - Word accepted at edge N; slice 0 is visible from edge N to edge N+1.
  - With out_ready held high, a word occupies exactly NUM cycles. Sustained throughput is one word per NUM cycles.
- Backpressure: with out_ready=0, out, out_idx and out_last hold stable and idx does not advance. out_valid never drops while BUSY.
- in_valid while BUSY and not on the last handshake: not accepted (in_ready=0). The producer must hold in stable until accepted.
- NUM==1 (chunk==width): every BUSY cycle is last. The block is a one-deep registered pipe with full throughput under out_ready=1.
- Widths:
  - idx is IW bits and never wraps past NUM-1; it is reloaded to 0 on each new word.
  - width not divisible by chunk is a configuration error: trigger an elaboration-time $error.
- Simultaneous events: async reset overrides every handshake in the same cycle.

Optional Feature:
- Macro: COREIR_UNCONCAT_MSB_FIRST_EN.
- Defined: slices are emitted MSB-first. The slice at step s is bits of index (NUM-1-s).
  - out_idx still counts 0..NUM-1 in emission order.
  - out_last still marks the final emitted slice.
  - Handshake and timing are unchanged.
- Undefined (default): LSB-first as above.

Test Plan:
- Reset then single word: release arst_n; in=16'hA5C3 with in_valid pulse; out_ready=1 → out = 3, C, 5, A on four consecutive cycles; out_idx=0..3; out_last=1 only with A; then out_valid=0, in_ready=1.
- Back-to-back: in_valid held with 16'h1234 then 16'hBEEF; out_ready=1 → out stream 4,3,2,1,F,E,E,B with no bubble; in_ready=1 only in IDLE and on each last beat.
- Backpressure: during word 16'h00F0, drop out_ready for 3 cycles at idx=1 → out stays F, out_idx stays 1, out_valid stays 1; stream resumes 0,0; total 7 cycles.
- Reset mid-word: assert arst_n low at idx=2 of 16'h8421 → out_valid=0 and out=0 immediately (async); after release no remaining slice is emitted; the next word 16'h0001 streams 1,0,0,0.
- Parameter sweep: width=8, chunk=8 with words 8'h11, 8'h22 back-to-back → one slice per cycle, out_last always 1. Also width=12, chunk=3 with 12'hFFF → four slices of 3'b111.
- With COREIR_UNCONCAT_MSB_FIRST_EN defined: in=16'hA5C3 → out = A, 5, C, 3; out_idx=0..3; out_last with 3.
